// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch slice: fetch FSM states,
// the IF/ID entry layout, default vectors and the PC step.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP            = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0180;
  localparam logic [31:0] PC_INC         = 32'd4;

  // One IF/ID (or skid) entry.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready port.
//   req   : fetch request, held with stable addr until ready
//   addr  : word-aligned fetch address
//   ready : rdata valid this cycle, completes the request
//   rdata : fetched instruction
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, addr, input ready, rdata);
  modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register plus a one-entry skid buffer.
//   ld_mem   : load {mem_inst, mem_pc, mem_pc+4, valid}
//   ld_skid  : load from the skid entry (if it holds one)
//   hold     : keep contents; otherwise the register takes a bubble
//   skid_wr  : capture the memory word into the skid
//   skid_clr : drop the skid entry
//   q        : current IF/ID contents
module if_id_reg import cpu_pkg::*; #(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_mem,
  input  logic        ld_skid,
  input  logic        hold,
  input  logic        skid_wr,
  input  logic        skid_clr,
  input  logic [31:0] mem_inst,
  input  logic [31:0] mem_pc,
  output if_id_t      q
);

  if_id_t in_ent;
  if_id_t skid;

  always_comb begin
    in_ent       = '0;
    in_ent.inst  = mem_inst;
    in_ent.pc    = mem_pc;
    in_ent.pc4   = mem_pc + PC_INC;  // wraps at 32 bits
    in_ent.valid = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '{inst: NOP, pc: RESET_PC, pc4: RESET_PC + PC_INC, valid: 1'b0};
      skid <= '0;
    end else begin
      if (ld_mem)                    q <= in_ent;
      else if (ld_skid && skid.valid) q <= skid;
      else if (!hold) begin
        // bubble keeps the old pc so id_pc stays meaningful for debug
        q.inst  <= NOP;
        q.valid <= 1'b0;
      end

      if (skid_clr)     skid.valid <= 1'b0;
      else if (skid_wr) skid       <= in_ent;
      else if (ld_skid) skid.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, drives the imem port and
// feeds the IF/ID register. Handles stalls (via skid), ID redirects,
// exception entry and eret, dropping wrong-path fetches.
//   clk, rst_n            : clock, async active-low reset
//   imem                  : instruction-memory master port
//   id_stall              : hold IF/ID
//   id_redirect/id_target : branch/jump redirect from ID
//   exc_take              : redirect to EXC_VECTOR
//   eret_take/epc         : redirect to epc
//   id_inst/pc/pc4/valid  : IF/ID contents to the decoder
module fetch_stage import cpu_pkg::*; #(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_stage_if.master imem,
  input  logic        id_stall,
  input  logic        id_redirect,
  input  logic [31:0] id_target,
  input  logic        exc_take,
  input  logic        eret_take,
  input  logic [31:0] epc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  fetch_state_t state;
  logic [31:0]  pc;        // next address to fetch
  logic [31:0]  req_addr;  // address of the request on the bus
  logic         req_q;
  logic         discard;   // outstanding request is wrong-path

  logic         redir;
  logic [31:0]  target;
  logic         accept;
  logic         ld_mem, ld_skid, hold, skid_wr;
  if_id_t       q;

  assign imem.req  = req_q;
  assign imem.addr = req_addr;

  assign redir = exc_take | eret_take | id_redirect;

  always_comb begin
    target = id_target;
    if (exc_take)       target = EXC_VECTOR;
    else if (eret_take) target = epc;
  end

  assign accept  = (state == S_REQ) && imem.ready;
  assign ld_mem  = accept && !discard && !id_stall && !redir;
  assign skid_wr = accept && !discard &&  id_stall && !redir;
  assign ld_skid = (state == S_HOLD) && !id_stall && !redir;
  // a redirect always bubbles IF/ID, even under stall
  assign hold    = id_stall && !redir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      req_q    <= 1'b0;
      discard  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_REQ;
          req_q <= 1'b1;
          if (redir) begin
            pc       <= target;
            req_addr <= target;
          end
        end
        S_REQ: begin
          if (redir) begin
            pc <= target;
            if (imem.ready) begin
              // data this cycle is simply dropped; nothing left in flight
              req_addr <= target;
              discard  <= 1'b0;
            end else begin
              // address must stay stable until ready; drop that beat later
              discard  <= 1'b1;
            end
          end else if (imem.ready) begin
            if (discard) begin
              discard  <= 1'b0;
              req_addr <= pc;
            end else begin
              pc       <= req_addr + PC_INC;
              req_addr <= req_addr + PC_INC;
              if (id_stall) begin
                state <= S_HOLD;
                req_q <= 1'b0;
              end
            end
          end
        end
        S_HOLD: begin
          if (redir) begin
            pc       <= target;
            req_addr <= target;
            state    <= S_REQ;
            req_q    <= 1'b1;
          end else if (!id_stall) begin
            state <= S_REQ;
            req_q <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(.RESET_PC(RESET_PC)) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_mem   (ld_mem),
    .ld_skid  (ld_skid),
    .hold     (hold),
    .skid_wr  (skid_wr),
    .skid_clr (redir),
    .mem_inst (imem.rdata),
    .mem_pc   (req_addr),
    .q        (q)
  );

  assign id_inst  = q.inst;
  assign id_pc    = q.pc;
  assign id_pc4   = q.pc4;
  assign id_valid = q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Memory returns rdata = addr + 0x1000.
// Outputs are sampled on the falling edge; inputs change right after.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        id_stall, id_redirect, exc_take, eret_take;
  logic [31:0] id_target, epc;
  logic [31:0] id_inst, id_pc, id_pc4;
  logic        id_valid;
  int          checks;
  int          errors;

  fetch_stage_if imem ();
  assign imem.rdata = imem.addr + 32'h1000;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem),
    .id_stall    (id_stall),
    .id_redirect (id_redirect),
    .id_target   (id_target),
    .exc_take    (exc_take),
    .eret_take   (eret_take),
    .epc         (epc),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4),
    .id_valid    (id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; imem.ready = 1'b0; id_stall = 1'b0; id_redirect = 1'b0;
    exc_take = 1'b0; eret_take = 1'b0; id_target = 32'h0; epc = 32'h0;
    repeat (3) @(negedge clk);
    if ({imem.req, id_valid, id_inst} !== {1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_out: req/valid/inst=%h exp 0", {imem.req, id_valid, id_inst});
    end
    checks++;
    if ({id_pc, id_pc4} !== {32'h0, 32'h4}) begin
      errors++; $display("FAIL reset_pc: pc/pc4=%h exp %h", {id_pc, id_pc4}, {32'h0, 32'h4});
    end
    checks++;
    rst_n = 1'b1;
    @(negedge clk);
    if ({imem.req, imem.addr} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL first_req: req/addr=%h exp %h", {imem.req, imem.addr}, {1'b1, 32'h0});
    end
    checks++;
    imem.ready = 1'b1;
  endtask

  task automatic test_stream();
    @(negedge clk);
    if ({id_valid, id_pc, id_inst, id_pc4, imem.addr} !== {1'b1, 32'h0, 32'h1000, 32'h4, 32'h4}) begin
      errors++; $display("FAIL stream0: v=%b pc=%h inst=%h pc4=%h addr=%h", id_valid, id_pc, id_inst, id_pc4, imem.addr);
    end
    checks++;
    @(negedge clk);
    if ({id_valid, id_pc, id_inst, id_pc4, imem.addr} !== {1'b1, 32'h4, 32'h1004, 32'h8, 32'h8}) begin
      errors++; $display("FAIL stream1: v=%b pc=%h inst=%h pc4=%h addr=%h", id_valid, id_pc, id_inst, id_pc4, imem.addr);
    end
    checks++;
  endtask

  task automatic test_wait_states();
    imem.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({id_valid, imem.req, imem.addr} !== {1'b0, 1'b1, 32'h8}) begin
        errors++; $display("FAIL wait%0d: v=%b req=%b addr=%h exp v=0 req=1 addr=8", i, id_valid, imem.req, imem.addr);
      end
      checks++;
    end
    imem.ready = 1'b1;
    @(negedge clk);
    if ({id_valid, id_pc, id_inst, id_pc4} !== {1'b1, 32'h8, 32'h1008, 32'hC}) begin
      errors++; $display("FAIL wait_done: v=%b pc=%h inst=%h pc4=%h exp 1/8/1008/c", id_valid, id_pc, id_inst, id_pc4);
    end
    checks++;
  endtask

  task automatic test_stall();
    repeat (2) @(negedge clk);
    if (id_pc !== 32'h10) begin
      errors++; $display("FAIL stall_pre: pc=%h exp 10", id_pc);
    end
    checks++;
    id_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if ({id_valid, id_pc, imem.req} !== {1'b1, 32'h10, 1'b0}) begin
        errors++; $display("FAIL stall_hold%0d: v=%b pc=%h req=%b exp 1/10/0", i, id_valid, id_pc, imem.req);
      end
      checks++;
    end
    id_stall = 1'b0;
    @(negedge clk);
    if ({id_valid, id_pc, id_inst, imem.req, imem.addr} !== {1'b1, 32'h14, 32'h1014, 1'b1, 32'h18}) begin
      errors++; $display("FAIL stall_skid: v=%b pc=%h inst=%h req=%b addr=%h exp 1/14/1014/1/18", id_valid, id_pc, id_inst, imem.req, imem.addr);
    end
    checks++;
    @(negedge clk);
    if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h18, 32'h1018}) begin
      errors++; $display("FAIL stall_after: v=%b pc=%h inst=%h exp 1/18/1018", id_valid, id_pc, id_inst);
    end
    checks++;
  endtask

  task automatic test_redirect_wait();
    @(negedge clk);
    if ({id_pc, imem.addr} !== {32'h1C, 32'h20}) begin
      errors++; $display("FAIL redir_pre: pc=%h addr=%h exp 1c/20", id_pc, imem.addr);
    end
    checks++;
    imem.ready = 1'b0; id_redirect = 1'b1; id_target = 32'h40;
    @(negedge clk);
    if ({id_valid, id_inst, imem.req, imem.addr} !== {1'b0, 32'h0, 1'b1, 32'h20}) begin
      errors++; $display("FAIL redir_bubble: v=%b inst=%h req=%b addr=%h exp 0/0/1/20", id_valid, id_inst, imem.req, imem.addr);
    end
    checks++;
    id_redirect = 1'b0; id_target = 32'h0;
    @(negedge clk);
    if ({id_valid, imem.addr} !== {1'b0, 32'h20}) begin
      errors++; $display("FAIL redir_stable: v=%b addr=%h exp 0/20", id_valid, imem.addr);
    end
    checks++;
    imem.ready = 1'b1;
    @(negedge clk);
    if ({id_valid, imem.addr} !== {1'b0, 32'h40}) begin
      errors++; $display("FAIL redir_drop: v=%b addr=%h exp 0/40", id_valid, imem.addr);
    end
    checks++;
    @(negedge clk);
    if ({id_valid, id_pc, id_inst, imem.addr} !== {1'b1, 32'h40, 32'h1040, 32'h44}) begin
      errors++; $display("FAIL redir_target: v=%b pc=%h inst=%h addr=%h exp 1/40/1040/44", id_valid, id_pc, id_inst, imem.addr);
    end
    checks++;
  endtask

  task automatic test_priority();
    exc_take = 1'b1; id_redirect = 1'b1; id_target = 32'h40;
    @(negedge clk);
    if ({id_valid, imem.addr} !== {1'b0, 32'h180}) begin
      errors++; $display("FAIL prio_exc: v=%b addr=%h exp 0/180", id_valid, imem.addr);
    end
    checks++;
    exc_take = 1'b0; id_redirect = 1'b0;
    @(negedge clk);
    if ({id_valid, id_pc, id_inst, imem.addr} !== {1'b1, 32'h180, 32'h1180, 32'h184}) begin
      errors++; $display("FAIL prio_exc_fetch: v=%b pc=%h inst=%h addr=%h exp 1/180/1180/184", id_valid, id_pc, id_inst, imem.addr);
    end
    checks++;
    eret_take = 1'b1; epc = 32'h24; id_redirect = 1'b1; id_target = 32'h40;
    @(negedge clk);
    if ({id_valid, id_inst, imem.addr} !== {1'b0, 32'h0, 32'h24}) begin
      errors++; $display("FAIL prio_eret: v=%b inst=%h addr=%h exp 0/0/24", id_valid, id_inst, imem.addr);
    end
    checks++;
    eret_take = 1'b0; id_redirect = 1'b0;
    @(negedge clk);
    if ({id_valid, id_pc, id_inst, id_pc4} !== {1'b1, 32'h24, 32'h1024, 32'h28}) begin
      errors++; $display("FAIL prio_eret_fetch: v=%b pc=%h inst=%h pc4=%h exp 1/24/1024/28", id_valid, id_pc, id_inst, id_pc4);
    end
    checks++;
  endtask

  task automatic test_wrap();
    id_redirect = 1'b1; id_target = 32'hFFFF_FFFC;
    @(negedge clk);
    if (imem.addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_addr: addr=%h exp fffffffc", imem.addr);
    end
    checks++;
    id_redirect = 1'b0;
    @(negedge clk);
    if ({id_pc, id_inst, id_pc4, imem.addr} !== {32'hFFFF_FFFC, 32'h0000_0FFC, 32'h0, 32'h0}) begin
      errors++; $display("FAIL wrap_pc4: pc=%h inst=%h pc4=%h addr=%h exp fffffffc/ffc/0/0", id_pc, id_inst, id_pc4, imem.addr);
    end
    checks++;
  endtask

  task automatic test_exc_in_hold();
    id_stall = 1'b1;
    @(negedge clk);
    if ({imem.req, id_valid, id_pc} !== {1'b0, 1'b1, 32'hFFFF_FFFC}) begin
      errors++; $display("FAIL hold_enter: req=%b v=%b pc=%h exp 0/1/fffffffc", imem.req, id_valid, id_pc);
    end
    checks++;
    exc_take = 1'b1;
    @(negedge clk);
    if ({imem.req, imem.addr, id_valid} !== {1'b1, 32'h180, 1'b0}) begin
      errors++; $display("FAIL hold_exc: req=%b addr=%h v=%b exp 1/180/0", imem.req, imem.addr, id_valid);
    end
    checks++;
    exc_take = 1'b0; id_stall = 1'b0;
    @(negedge clk);
    if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h180, 32'h1180}) begin
      errors++; $display("FAIL hold_skid_clr: v=%b pc=%h inst=%h exp 1/180/1180", id_valid, id_pc, id_inst);
    end
    checks++;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_wait_states();
    test_stall();
    test_redirect_wait();
    test_priority();
    test_wrap();
    test_exc_in_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
